// File: rtl/clock_pkg.sv
// Shared types and constants for the clock/calendar button front end.
package clock_pkg;

  // Per-button conditioner state.
  typedef enum logic [2:0] {
    RELEASED,
    PRESS_WAIT,
    HELD_DELAY,
    HELD_REPEAT,
    RELEASE_WAIT
  } btn_state_t;

  // Button roles by index on the KEY bus.
  localparam int unsigned BTN_INC = 0;
  localparam int unsigned BTN_DEC = 1;
  localparam int unsigned BTN_CHG = 2;

  // System clock frequency; default timing parameters are derived from it.
  localparam int unsigned CLK_HZ = 50_000_000;

  // Largest of three cycle counts.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Counter width able to hold the largest cycle count itself.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM, shared cycle counter.
// Auto-repeat counting is compiled in only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = CLK_HZ / 100,
  parameter int unsigned REPEAT_DELAY_CYC = CLK_HZ / 2,
  parameter int unsigned REPEAT_RATE_CYC  = CLK_HZ / 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic butt_n_i,
  output logic press_o,
  output logic step_o,
  output logic held_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC);

  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYC);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] DLY_LAST_C  = CW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST_C = CW'(REPEAT_RATE_CYC - 1);
`endif

  logic [1:0]    sync_q;
  logic          sync_n;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
`ifdef BTN_AUTOREPEAT_EN
  logic          step_q, step_d;
`endif

  // Two-stage synchroniser; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], butt_n_i};
    end
  end

  assign sync_n = sync_q[1];

  // State, counter and registered pulse flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      step_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
`ifdef BTN_AUTOREPEAT_EN
      step_q  <= step_d;
`endif
    end
  end

  // Next-state, counter and pulse decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    step_d  = 1'b0;
`endif
    unique case (state_q)
      RELEASED: begin
        if (!sync_n) begin
          state_d = PRESS_WAIT;
          cnt_d   = ONE_C;
        end
      end

      PRESS_WAIT: begin
        if (sync_n) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d = HELD_DELAY;
          cnt_d   = '0;
          press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          step_d  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end

      HELD_DELAY: begin
        // Release is checked first so a coincident repeat is dropped.
        if (sync_n) begin
          state_d = RELEASE_WAIT;
          cnt_d   = ONE_C;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (cnt_q == DLY_LAST_C) begin
          state_d = HELD_REPEAT;
          cnt_d   = '0;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
`endif
      end

`ifdef BTN_AUTOREPEAT_EN
      HELD_REPEAT: begin
        if (sync_n) begin
          state_d = RELEASE_WAIT;
          cnt_d   = ONE_C;
        end else if (cnt_q == RATE_LAST_C) begin
          cnt_d  = '0;
          step_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
`endif

      RELEASE_WAIT: begin
        // A renewed low resumes the hold without a second press pulse.
        if (!sync_n) begin
          state_d = HELD_DELAY;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: held is decoded from state, pulses come straight from flops.
  always_comb begin
    held_o  = (state_q == HELD_DELAY) || (state_q == HELD_REPEAT) ||
              (state_q == RELEASE_WAIT);
    press_o = press_q;
`ifdef BTN_AUTOREPEAT_EN
    step_o  = step_q;
`else
    step_o  = press_q;
`endif
  end

endmodule

// File: rtl/button_conditioner.sv
// Button front end for the clock/calendar counter: one independent
// conditioning channel per active-low KEY input.
// Optional auto-repeat on step outputs: define BTN_AUTOREPEAT_EN.
module button_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned NBTN             = 3,
  parameter int unsigned DEBOUNCE_CYC     = CLK_HZ / 100,
  parameter int unsigned REPEAT_DELAY_CYC = CLK_HZ / 2,
  parameter int unsigned REPEAT_RATE_CYC  = CLK_HZ / 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] butt_n,
  output logic [NBTN-1:0] press,
  output logic [NBTN-1:0] step,
  output logic [NBTN-1:0] held
);

  for (genvar g = 0; g < NBTN; g++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .butt_n_i (butt_n[g]),
      .press_o  (press[g]),
      .step_o   (step[g]),
      .held_o   (held[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with short timing parameters.
module tb_button_conditioner;
  import clock_pkg::*;

  localparam int unsigned NB = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RR = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] butt_n;
  logic [NB-1:0] press, step, held;

  always #5 clk = ~clk;

  button_conditioner #(
    .NBTN             (NB),
    .DEBOUNCE_CYC     (D),
    .REPEAT_DELAY_CYC (RD),
    .REPEAT_RATE_CYC  (RR)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .butt_n (butt_n),
    .press  (press),
    .step   (step),
    .held   (held)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: debounced level flips after D+1 consecutive edges of
  // opposing synchronised input; repeats fall at anchor+RD+k*RR while the
  // debounced press has no opposing input in progress.
  logic [NB-1:0] m_s1, m_s2, m_deb, m_press, m_step;
  int            m_mis[NB];
  int            m_anchor[NB];
  int            m_t;

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_deb = '0; m_press = '0; m_step = '0;
    for (int i = 0; i < NB; i++) begin m_mis[i] = 0; m_anchor[i] = 0; end
  endtask

  task automatic model_step();
    m_t++;
    for (int i = 0; i < NB; i++) begin
      logic lvl;
      int   dt;
      lvl = ~m_s2[i];
      m_press[i] = 1'b0;
      m_step[i]  = 1'b0;
      if (lvl != m_deb[i]) begin
        m_mis[i]++;
        if (m_mis[i] == D + 1) begin
          m_deb[i] = lvl;
          m_mis[i] = 0;
          if (lvl) begin
            m_press[i]  = 1'b1;
            m_step[i]   = 1'b1;
            m_anchor[i] = m_t;
          end
        end
      end else begin
        if (m_mis[i] > 0 && m_deb[i]) m_anchor[i] = m_t;
        m_mis[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
        dt = m_t - m_anchor[i];
        if (m_deb[i] && dt >= RD && ((dt - RD) % RR) == 0) m_step[i] = 1'b1;
`else
        dt = 0;
`endif
      end
    end
    m_s2 = m_s1;
    m_s1 = butt_n;
  endtask

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: model advances at the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    chk("model_press", press, m_press);
    chk("model_step", step, m_step);
    chk("model_held", held, m_held_vec());
  endtask

  function automatic logic [NB-1:0] m_held_vec();
    return m_deb;
  endfunction

  task automatic idle(input int n);
    butt_n = '1;
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic bit ar_step_edge(input int e);
`ifdef BTN_AUTOREPEAT_EN
    return e == 6 || e == 16 || e == 21 || e == 26 || e == 31 || e == 36 || e == 41;
`else
    return e == 6;
`endif
  endfunction

  typedef struct {
    logic [NB-1:0] mask;
    int            hold;
    int            exp_press;
    int            exp_step_ar;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] b_inc, b_dec, exp_v;
    int            run[NB];
    int            pc[NB], sc[NB];

    tbl[0] = '{3'b001,  3, 0, 0};
    tbl[1] = '{3'b010,  5, 1, 1};
    tbl[2] = '{3'b100,  8, 1, 1};
    tbl[3] = '{3'b111, 14, 1, 1};
    tbl[4] = '{3'b001, 15, 1, 2};
    tbl[5] = '{3'b011, 25, 1, 4};
    tbl[6] = '{3'b100, 20, 1, 3};

    b_inc = '0; b_inc[BTN_INC] = 1'b1;
    b_dec = '0; b_dec[BTN_DEC] = 1'b1;

    // Reset state
    rst_n  = 1'b0;
    butt_n = '1;
    m_t    = 0;
    model_reset();
    tick(); tick();
    chk("reset_press", press, '0);
    chk("reset_step", step, '0);
    chk("reset_held", held, '0);
    rst_n = 1'b1;
    idle(3);

    // Clean press on increase, held 8 cycles
    for (int e = 0; e < 19; e++) begin
      butt_n = '1;
      if (e < 8) butt_n[BTN_INC] = 1'b0;
      tick();
      chk("clean_press", press, (e == 6) ? b_inc : '0);
      chk("clean_held", held, (e >= 6 && e <= 13) ? b_inc : '0);
    end
    idle(4);

    // Bounce on decrease, then steady low
    for (int e = 0; e < 21; e++) begin
      butt_n = '1;
      butt_n[BTN_DEC] = !(e < 2 || (e >= 4 && e < 6) || e >= 8);
      tick();
      chk("bounce_press", press, (e == 14) ? b_dec : '0);
    end
    idle(10);

    // Long hold on increase: repeat pattern, release drops the repeat at 46
    for (int e = 0; e < 56; e++) begin
      butt_n = '1;
      if (e < 44) butt_n[BTN_INC] = 1'b0;
      tick();
      chk("hold_press", press, (e == 6) ? b_inc : '0);
      chk("hold_step", step, ar_step_edge(e) ? b_inc : '0);
    end
    idle(4);

    // All three pressed on the same edge
    for (int e = 0; e < 19; e++) begin
      butt_n = (e < 8) ? '0 : '1;
      tick();
      chk("all_press", press, (e == 6) ? '1 : '0);
    end
    idle(4);

    // Reset while holding past the first repeat, button kept down
    for (int e = 0; e < 19; e++) begin
      butt_n = '1;
      butt_n[BTN_INC] = 1'b0;
      tick();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_press", press, '0);
    chk("rst_mid_step", step, '0);
    chk("rst_mid_held", held, '0);
    for (int k = 0; k < 3; k++) tick();
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      chk("rst_redo_press", press, (e == 6) ? b_inc : '0);
      chk("rst_redo_held", held, (e >= 6) ? b_inc : '0);
    end
    idle(10);

    // Table of hold lengths: pulse counts per button
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NB; i++) begin pc[i] = 0; sc[i] = 0; end
      for (int e = 0; e < tbl[v].hold + 14; e++) begin
        butt_n = (e < tbl[v].hold) ? ~tbl[v].mask : '1;
        tick();
        for (int i = 0; i < NB; i++) begin
          pc[i] += int'(press[i]);
          sc[i] += int'(step[i]);
        end
      end
      for (int i = 0; i < NB; i++) begin
`ifdef BTN_AUTOREPEAT_EN
        chk_int($sformatf("tbl%0d_step%0d", v, i), sc[i], tbl[v].mask[i] ? tbl[v].exp_step_ar : 0);
`else
        chk_int($sformatf("tbl%0d_step%0d", v, i), sc[i], tbl[v].mask[i] ? tbl[v].exp_press : 0);
`endif
        chk_int($sformatf("tbl%0d_press%0d", v, i), pc[i], tbl[v].mask[i] ? tbl[v].exp_press : 0);
      end
    end

    // Random runs: bounces mixed with long holds, one reset in the middle
    for (int i = 0; i < NB; i++) run[i] = 1;
    butt_n = '1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NB; i++) begin
        run[i]--;
        if (run[i] == 0) begin
          butt_n[i] = ~butt_n[i];
          run[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                               : int'($urandom_range(3, 60));
        end
      end
      if (c == 2000) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        exp_v = '0;
        chk("rand_rst_held", held, exp_v);
        tick(); tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
